// File: rtl/sik_prog_encoder_if.sv
// Request/write bus for the SIK program encoder: symbolic instruction in,
// encoded words out toward instruction memory, plus status.
interface sik_prog_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_ext;
  logic [3:0]  in_op;
  logic [15:0] in_imm;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        err;
  logic        full;
  logic [16:0] words;

  modport master (
    output in_valid, in_ext, in_op, in_imm,
    input  in_ready, mem_we, mem_addr, mem_data, err, full, words
  );

  modport slave (
    input  in_valid, in_ext, in_op, in_imm,
    output in_ready, mem_we, mem_addr, mem_data, err, full, words
  );
endinterface

// File: rtl/sik_prog_encoder.sv
// SIK instruction encoder: turns opcode+immediate requests into 16-bit words,
// adding a prefix word for wide immediates, and writes them to sequential addresses.
module sik_prog_encoder #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] LAST = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  sik_prog_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR_PRE, WR_OP} state_t;

  state_t      state;
  logic [15:0] held_op;
  logic        op_ok;
  logic        needs_pre;
  logic [15:0] enc_word;
  logic [15:0] pre_word;
  logic [15:0] slot;
  logic        last_write;
  logic        room_ok;
  logic        transfer;

  assign bus.in_ready = !bus.full && (state == IDLE || state == WR_OP);
  assign transfer     = bus.in_valid && bus.in_ready;

  // slot is where the first word of a newly accepted request would land
  always_comb begin
    op_ok      = bus.in_ext ? (bus.in_op >= 4'd1 && bus.in_op <= 4'd12)
                            : (bus.in_op >= 4'd1 && bus.in_op <= 4'd8);
    needs_pre  = !bus.in_ext && (bus.in_imm[15:12] != {4{bus.in_imm[11]}});
    enc_word   = bus.in_ext ? {12'h000, bus.in_op} : {bus.in_op, bus.in_imm[11:0]};
    pre_word   = {4'hF, 8'h00, bus.in_imm[15:12]};
    slot       = bus.mem_we ? bus.mem_addr + 16'd1 : bus.mem_addr;
    last_write = bus.mem_we && (bus.mem_addr == LAST);
    room_ok    = !last_write && !(needs_pre && slot == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      held_op      <= 16'h0000;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= BASE;
      bus.mem_data <= 16'h0000;
      bus.err      <= 1'b0;
      bus.full     <= 1'b0;
      bus.words    <= 17'd0;
    end else begin
      bus.err <= 1'b0;
      if (bus.mem_we) begin
        bus.words <= bus.words + 17'd1;
        if (bus.mem_addr == LAST)
          bus.full <= 1'b1;
        else
          bus.mem_addr <= bus.mem_addr + 16'd1;
      end

      case (state)
        WR_PRE: begin
          if (last_write) begin
            state      <= IDLE;
            bus.mem_we <= 1'b0;
          end else begin
            state        <= WR_OP;
            bus.mem_we   <= 1'b1;
            bus.mem_data <= held_op;
          end
        end
        default: begin
          if (transfer && op_ok && room_ok) begin
            bus.mem_we <= 1'b1;
            if (needs_pre) begin
              state        <= WR_PRE;
              bus.mem_data <= pre_word;
              held_op      <= enc_word;
            end else begin
              state        <= WR_OP;
              bus.mem_data <= enc_word;
            end
          end else begin
            // a rejected request still completes its handshake, it just pulses err
            if (transfer)
              bus.err <= 1'b1;
            state      <= IDLE;
            bus.mem_we <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sik_prog_encoder.sv
// Bench for sik_prog_encoder: directed scenarios with literal expectations plus
// randomized requests checked every cycle against a word-queue model.
module tb_sik_prog_encoder;

  localparam logic [15:0] MODEL_LAST = 16'hFFFF;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sik_prog_encoder_if bus0();
  sik_prog_encoder_if bus1();

  sik_prog_encoder #(.BASE(16'h0000), .LAST(16'hFFFF)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  sik_prog_encoder #(.BASE(16'hFFFE), .LAST(16'hFFFF)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit model_en    = 1'b0;

  // model state: everything still to be written lives in a plain queue
  logic [15:0] m_addr;
  logic [16:0] m_words;
  bit          m_full;
  bit          m_we;
  bit          m_err;
  logic [15:0] m_data;
  logic [15:0] pend[$];
  bit          m_rdy, m_last_write, m_legal, m_pre;
  logic [15:0] m_slot, m_imm;
  logic [3:0]  m_op;
  bit          m_ext;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_addr  = 16'h0000;
      m_words = 17'd0;
      m_full  = 1'b0;
      m_we    = 1'b0;
      m_err   = 1'b0;
      m_data  = 16'h0000;
      pend.delete();
    end else begin
      m_rdy        = !m_full && pend.size() == 0;
      m_slot       = m_we ? m_addr + 16'd1 : m_addr;
      m_last_write = m_we && m_addr == MODEL_LAST;
      if (m_we) begin
        m_words = m_words + 17'd1;
        if (m_addr == MODEL_LAST) m_full = 1'b1;
        else m_addr = m_addr + 16'd1;
      end
      m_err = 1'b0;
      if (bus0.in_valid && m_rdy) begin
        m_ext   = bus0.in_ext;
        m_op    = bus0.in_op;
        m_imm   = bus0.in_imm;
        m_legal = m_ext ? (m_op >= 1 && m_op <= 12) : (m_op >= 1 && m_op <= 8);
        m_pre   = !m_ext && !($signed(m_imm) >= -2048 && $signed(m_imm) <= 2047);
        if (!m_legal || m_last_write || (m_pre && m_slot == MODEL_LAST)) begin
          m_err = 1'b1;
        end else begin
          if (m_pre) pend.push_back({4'hF, 8'h00, m_imm[15:12]});
          pend.push_back(m_ext ? {12'h000, m_op} : {m_op, m_imm[11:0]});
        end
      end
      if (pend.size() > 0 && !m_full) begin
        m_we   = 1'b1;
        m_data = pend.pop_front();
      end else begin
        m_we = 1'b0;
        pend.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      checkOutput("model_we", bus0.mem_we, m_we);
      checkOutput("model_addr", bus0.mem_addr, m_addr);
      if (m_we) checkOutput("model_data", bus0.mem_data, m_data);
      checkOutput("model_err", bus0.err, m_err);
      checkOutput("model_full", bus0.full, m_full);
      checkOutput("model_words", bus0.words, m_words);
      checkOutput("model_ready", bus0.in_ready, !m_full && pend.size() == 0);
    end
  end

  // drives a request and returns at the negedge just after it was accepted
  task automatic applyStimulus(input int sel, input bit ext, input logic [3:0] op,
                               input logic [15:0] imm);
    bit rdy;
    if (sel == 0) begin
      bus0.in_valid = 1'b1; bus0.in_ext = ext; bus0.in_op = op; bus0.in_imm = imm;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_ext = ext; bus1.in_op = op; bus1.in_imm = imm;
    end
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) checkOutput("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.in_ext = 1'b0; bus0.in_op = 4'd0; bus0.in_imm = 16'h0;
    bus1.in_valid = 1'b0; bus1.in_ext = 1'b0; bus1.in_op = 4'd0; bus1.in_imm = 16'h0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_en = 1'b1;
    checkOutput("rst_addr", bus0.mem_addr, 16'h0000);
    checkOutput("rst_words", bus0.words, 17'd0);
    checkOutput("rst_full", bus0.full, 1'b0);
    checkOutput("rst_we", bus0.mem_we, 1'b0);
    checkOutput("rst_addr_hi", bus1.mem_addr, 16'hFFFE);
    reset = 1'b1;

    applyStimulus(0, 1'b0, 4'd1, 16'h0005);
    checkOutput("get_we", bus0.mem_we, 1'b1);
    checkOutput("get_addr", bus0.mem_addr, 16'h0000);
    checkOutput("get_data", bus0.mem_data, 16'h1005);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("get_words", bus0.words, 17'd1);

    doReset();
    applyStimulus(0, 1'b0, 4'd8, 16'h1234);
    checkOutput("push_pre_data", bus0.mem_data, 16'hF001);
    checkOutput("push_pre_addr", bus0.mem_addr, 16'h0000);
    checkOutput("push_pre_ready", bus0.in_ready, 1'b0);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("push_op_data", bus0.mem_data, 16'h8234);
    checkOutput("push_op_addr", bus0.mem_addr, 16'h0001);
    applyStimulus(0, 1'b0, 4'd8, 16'hFFF0);
    checkOutput("push_neg_data", bus0.mem_data, 16'h8FF0);
    checkOutput("push_neg_addr", bus0.mem_addr, 16'h0002);
    bus0.in_valid = 1'b0;
    @(negedge clk);

    doReset();
    applyStimulus(0, 1'b1, 4'd1, 16'hABCD);
    checkOutput("add_data", bus0.mem_data, 16'h0001);
    checkOutput("add_addr", bus0.mem_addr, 16'h0000);
    applyStimulus(0, 1'b1, 4'd7, 16'h1234);
    checkOutput("dup_data", bus0.mem_data, 16'h0007);
    checkOutput("dup_addr", bus0.mem_addr, 16'h0001);
    applyStimulus(0, 1'b1, 4'd8, 16'h0000);
    checkOutput("ret_data", bus0.mem_data, 16'h0008);
    checkOutput("ret_addr", bus0.mem_addr, 16'h0002);
    bus0.in_valid = 1'b0;
    @(negedge clk);

    applyStimulus(0, 1'b0, 4'hF, 16'h0000);
    checkOutput("bad_norm_err", bus0.err, 1'b1);
    checkOutput("bad_norm_we", bus0.mem_we, 1'b0);
    checkOutput("bad_norm_addr", bus0.mem_addr, 16'h0003);
    checkOutput("bad_norm_words", bus0.words, 17'd3);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bad_norm_err_off", bus0.err, 1'b0);
    applyStimulus(0, 1'b1, 4'hD, 16'h0000);
    checkOutput("bad_ext_err", bus0.err, 1'b1);
    checkOutput("bad_ext_we", bus0.mem_we, 1'b0);
    checkOutput("bad_ext_addr", bus0.mem_addr, 16'h0003);
    bus0.in_valid = 1'b0;
    @(negedge clk);

    doReset();
    applyStimulus(1, 1'b0, 4'd3, 16'h0010);
    checkOutput("hi_jump_we", bus1.mem_we, 1'b1);
    checkOutput("hi_jump_addr", bus1.mem_addr, 16'hFFFE);
    checkOutput("hi_jump_data", bus1.mem_data, 16'h3010);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b0, 4'd2, 16'h2000);
    checkOutput("hi_put_err", bus1.err, 1'b1);
    checkOutput("hi_put_we", bus1.mem_we, 1'b0);
    checkOutput("hi_put_addr", bus1.mem_addr, 16'hFFFF);
    checkOutput("hi_put_words", bus1.words, 17'd1);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b1, 4'd7, 16'h0000);
    checkOutput("hi_dup_we", bus1.mem_we, 1'b1);
    checkOutput("hi_dup_addr", bus1.mem_addr, 16'hFFFF);
    checkOutput("hi_dup_data", bus1.mem_data, 16'h0007);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("hi_full", bus1.full, 1'b1);
    checkOutput("hi_ready", bus1.in_ready, 1'b0);
    checkOutput("hi_addr_hold", bus1.mem_addr, 16'hFFFF);
    checkOutput("hi_words", bus1.words, 17'd2);
    bus1.in_valid = 1'b1; bus1.in_ext = 1'b1; bus1.in_op = 4'd1;
    repeat (3) @(negedge clk);
    checkOutput("hi_full_we", bus1.mem_we, 1'b0);
    checkOutput("hi_full_words", bus1.words, 17'd2);
    bus1.in_valid = 1'b0;

    doReset();
    applyStimulus(0, 1'b0, 4'd8, 16'h1234);
    reset = 1'b0;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_we", bus0.mem_we, 1'b0);
    checkOutput("rst_pre_addr", bus0.mem_addr, 16'h0000);
    checkOutput("rst_pre_words", bus0.words, 17'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_pre_no_op", bus0.mem_we, 1'b0);

    for (int n = 0; n < 400; n++) begin
      int gap;
      logic [15:0] imm;
      gap = $urandom_range(0, 3);
      if (gap > 1) begin
        bus0.in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
      if ($urandom_range(0, 63) == 0) begin
        doReset();
      end
      case ($urandom_range(0, 2))
        0: imm = 16'($urandom);
        1: imm = {{4{1'b0}}, 12'($urandom)};
        default: imm = 16'($signed(12'($urandom)));
      endcase
      applyStimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), imm);
    end
    bus0.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sik_prog_encoder.md
Name: sik_prog_encoder

Overview:
Sequential instruction encoder and program writer. It is the producing end of the SIK instruction stream that the pipelined core fetches and decodes.
- Accepts symbolic instructions (opcode plus 16-bit immediate) over a valid/ready handshake.
- Encodes each one into 16-bit instruction words, inserting a `pre` prefix word when the immediate does not fit in 12 bits.
- Writes the words to sequential memory addresses, for loading instruction memory before the core leaves reset.

Parameters:
BASE, 16'h0000, first memory address written after reset
LAST, 16'hFFFF, highest writable address; no wrap-around beyond it

Ports:
clk  input  1  clock; all state changes on posedge clk
reset  input  1  reset, active-low
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept a request this cycle
in_ext  input  1  0 = normal opcode, 1 = extended opcode
in_op  input  4  normal opcode (get..push = 1..8) or extended opcode (add..test = 1..12)
in_imm  input  16  immediate; ignored when in_ext=1
mem_we  output  1  write strobe, one word per cycle
mem_addr  output  16  write address
mem_data  output  16  encoded instruction word
err  output  1  one-cycle pulse: accepted request was rejected and not written
full  output  1  address LAST has been written; no further writes
words  output  17  total words written since reset

Behaviour:
- Reset: synchronous, active-low. Sampled on posedge clk while reset==0.
  - Outputs after reset: mem_we=0, mem_addr=BASE, mem_data=0, err=0, full=0, words=0, state=IDLE.
  - Reset mid-sequence abandons any pending word; no write occurs in the cycle following the reset edge.
- Handshake:
  - A transfer occurs on a posedge where in_valid && in_ready.
  - in_ready = !full && (state==IDLE || state==WR_OP). It never depends on in_* values.
- Encoding:
  - Normal, in_ext=0, in_op in 1..8: op word = {in_op, in_imm[11:0]}.
    - needs_pre = (in_imm[15:12] != {4{in_imm[11]}}).
    - Pre word = {4'b1111, 8'h00, in_imm[15:12]}.
  - Extended, in_ext=1, in_op in 1..12: word = {4'b0000, 8'h00, in_op}. Never needs a pre word.
  - Invalid requests: in_ext=0 with in_op in {0, 9..15}, or in_ext=1 with in_op in {0, 13..15}.
    - The transfer completes, err=1 the next cycle, no write.
  - Insufficient room: needs_pre && mem_addr==LAST at acceptance.
    - Handled as invalid (err pulse, no write), so a prefix is never orphaned.
- States:
  - IDLE: mem_we=0.
  - WR_PRE: mem_we=1, mem_data=pre word.
  - WR_OP: mem_we=1, mem_data=op word.
- Transitions:
  - Valid transfer from IDLE or WR_OP → WR_PRE if needs_pre, else → WR_OP.
  - WR_PRE → WR_OP unconditionally; in_ready=0 while in WR_PRE.
  - WR_OP with no transfer → IDLE.
  - Invalid transfer → IDLE.
  - Any state with full set → IDLE after the current write.
- Latency:
  - Word without prefix: written in the cycle after acceptance.
  - Word with prefix: pre word 1 cycle after acceptance, op word 2 cycles after.
  - Throughput: 1 word/cycle when no prefixes are needed (back-to-back accepts in WR_OP).
- Address and count:
  - After each cycle with mem_we=1, mem_addr increments by 1 and words increments by 1.
  - When the word at LAST is written, full becomes 1 on that edge and mem_addr holds LAST (no wrap).
  - full is sticky until reset.
- Request capture: operands are latched at acceptance; in_* may change freely afterwards.

Test Plan:
- Reset with reset=0 on one edge → mem_addr=0000, words=0, full=0, mem_we=0. Then get imm=0x005 → next cycle mem_we=1, addr=0000, data=0x1005; words=1.
- push imm=0x1234 → pre 0xF001 @0000, then 0x8234 @0001, in_ready=0 during WR_PRE. push imm=0xFFF0 → single word 0x8FF0, no pre.
- Extended stream add, dup, ret presented back-to-back with in_valid held → data 0x0001, 0x0007, 0x0008 on 3 consecutive cycles at addrs 0,1,2.
- in_ext=0, in_op=0xF; then in_ext=1, in_op=0xD → each: err pulse 1 cycle, mem_we=0, mem_addr unchanged, words unchanged.
- BASE=FFFE: jump imm=0x0010, then put imm=0x2000 → jump written @FFFE. put is rejected with err, since a prefix is needed and mem_addr=FFFF==LAST. A further dup → written @FFFF, full=1, in_ready=0, mem_addr stays FFFF.
- Assert reset in the WR_PRE cycle of a prefixed push → the op word is never written, mem_addr=BASE, words=0 on the following cycle.
